// File: rtl/pe_operand_sequencer.sv
// Feeds paired ifmap/filter words into one PE and collects each window's psum in a result FIFO.
// Optional build macro PSUM_RELU_EN clamps negative psums to zero before they enter the FIFO.
module pe_operand_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int PE_LAT     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8,
   parameter int WIN_W      = 12
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [LEN_W-1:0]        cfg_len,
   input  logic [WIN_W-1:0]        cfg_num_win,
   output logic                    busy,
   output logic                    done,
   input  logic                    ifmap_valid,
   output logic                    ifmap_ready,
   input  logic [DATA_WIDTH-1:0]   ifmap_data,
   input  logic                    fltr_valid,
   output logic                    fltr_ready,
   input  logic [DATA_WIDTH-1:0]   fltr_data,
   output logic [DATA_WIDTH-1:0]   pe_ifmap,
   output logic [DATA_WIDTH-1:0]   pe_fltr,
   output logic                    pe_mult_seln,
   output logic                    pe_acc_seln,
   input  logic [2*DATA_WIDTH-1:0] pe_psum,
   output logic                    psum_valid,
   input  logic                    psum_ready,
   output logic [2*DATA_WIDTH-1:0] psum_data
);

   localparam int PW = 2*DATA_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int TW = $clog2(PE_LAT+2);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t                state_q;
   logic [LEN_W-1:0]      len_q, elem_q, elem_d;
   logic [WIN_W-1:0]      nwin_q, win_q, win_d;
   logic                  busy_q, done_q, acc_q;
   logic [DATA_WIDTH-1:0] ifm_q, flt_q;
   logic [PE_LAT:0]       tag_q;
   logic [PW-1:0]         mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;
   logic [TW-1:0]         inflight;
   logic                  room, issue, last_elem, last_win, push, pop;
   logic [PW-1:0]         push_data;

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i <= unsigned'(PE_LAT); i++)
         inflight = inflight + TW'(tag_q[i]);
   end

   // Results still inside the PE count against FIFO space so a capture never meets a full FIFO.
   assign room      = (32'(cnt_q) + 32'(inflight)) < 32'(FIFO_DEPTH);
   assign issue     = (state_q == RUN) & ifmap_valid & fltr_valid & room;
   assign last_elem = (elem_q == len_q - LEN_W'(1));
   assign last_win  = (win_q == nwin_q - WIN_W'(1));
   assign elem_d    = last_elem ? '0 : elem_q + LEN_W'(1);
   assign win_d     = last_elem ? win_q + WIN_W'(1) : win_q;
   assign push      = tag_q[PE_LAT];
   assign pop       = psum_valid & psum_ready;

`ifdef PSUM_RELU_EN
   assign push_data = pe_psum[PW-1] ? '0 : pe_psum;
`else
   assign push_data = pe_psum;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         len_q   <= '0;
         nwin_q  <= '0;
         elem_q  <= '0;
         win_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ifm_q   <= '0;
         flt_q   <= '0;
         acc_q   <= 1'b0;
         tag_q   <= '0;
      end else begin
         done_q <= 1'b0;
         ifm_q  <= issue ? ifmap_data : '0;
         flt_q  <= issue ? fltr_data : '0;
         acc_q  <= issue & (elem_q == '0);
         tag_q  <= {tag_q[PE_LAT-1:0], issue & last_elem};
         case (state_q)
            IDLE: begin
               if (start) begin
                  if ((cfg_len != '0) && (cfg_num_win != '0)) begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                     len_q   <= cfg_len;
                     nwin_q  <= cfg_num_win;
                     elem_q  <= '0;
                     win_q   <= '0;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  elem_q <= elem_d;
                  win_q  <= win_d;
                  if (last_elem && last_win) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if ((inflight == '0) && (cnt_q == '0)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < unsigned'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign ifmap_ready  = issue;
   assign fltr_ready   = issue;
   assign pe_ifmap     = ifm_q;
   assign pe_fltr      = flt_q;
   assign pe_acc_seln  = acc_q;
   assign pe_mult_seln = 1'b1;
   assign psum_valid   = (cnt_q != '0);
   assign psum_data    = psum_valid ? mem_q[rd_q] : '0;

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Bench for pe_operand_sequencer: directed table plus random jobs checked against a window-sum model
// and a cycle model of stream readiness, result availability and job completion.
module tb_pe_operand_sequencer;

   localparam int DW = 16, PE_LAT = 3, DEPTH = 4, LEN_W = 8, WIN_W = 12;

   logic             clk = 1'b0, rstn = 1'b0, start = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic [WIN_W-1:0] cfg_num_win = '0;
   logic             busy, done, ifmap_ready, fltr_ready, pe_mult_seln, pe_acc_seln, psum_valid;
   logic             ifmap_valid = 1'b0, fltr_valid = 1'b0, psum_ready = 1'b0;
   logic [DW-1:0]    ifmap_data = '0, fltr_data = '0, pe_ifmap, pe_fltr;
   logic [2*DW-1:0]  pe_psum, psum_data;

   always #5 clk = ~clk;

   pe_operand_sequencer #(.DATA_WIDTH(DW), .PE_LAT(PE_LAT), .FIFO_DEPTH(DEPTH),
                          .LEN_W(LEN_W), .WIN_W(WIN_W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len), .cfg_num_win(cfg_num_win),
      .busy(busy), .done(done),
      .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
      .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
      .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_mult_seln(pe_mult_seln), .pe_acc_seln(pe_acc_seln),
      .pe_psum(pe_psum), .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data));

   function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa, sb;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return 32'(sa * sb);
   endfunction

   // PE stand-in: accumulate stage followed by PE_LAT-1 delay stages
   logic [31:0] pe_line [PE_LAT];
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < PE_LAT; i++) pe_line[i] <= '0;
      end else begin
         pe_line[0] <= pe_acc_seln ? prod(pe_ifmap, pe_fltr)
                                   : pe_line[0] + (pe_mult_seln ? prod(pe_ifmap, pe_fltr) : 32'd0);
         for (int i = 1; i < PE_LAT; i++) pe_line[i] <= pe_line[i-1];
      end
   end
   assign pe_psum = pe_line[PE_LAT-1];

   int total = 0, bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_ifmap_ready"}, ifmap_ready, 1'b0);
      check({tag, "_fltr_ready"}, fltr_ready, 1'b0);
      check({tag, "_pe_ifmap"}, pe_ifmap, 16'h0);
      check({tag, "_pe_fltr"}, pe_fltr, 16'h0);
      check({tag, "_pe_acc_seln"}, pe_acc_seln, 1'b0);
      check({tag, "_pe_mult_seln"}, pe_mult_seln, 1'b1);
      check({tag, "_psum_valid"}, psum_valid, 1'b0);
      check({tag, "_psum_data"}, psum_data, 32'h0);
   endtask

   // mode: 0 random, 1 ifmap 1..len / fltr 5.., 2 const 2*3, 3 ramp*1, 4 (-3)*4
   typedef struct {
      int len, win, mode, pv, tog, pr, hold, spur;
      int exp_n, chk_first, exp_lat, exp_acc, exp_hold_iss, abort;
      logic [31:0] exp_psum;
   } vec_t;

   task automatic run_job(input vec_t v);
      logic [15:0] ifd[$], fd[$];
      logic [31:0] expq[$], s, first_psum;
      int win_t[$];
      int n, iss, pops, dut_pops, wdone, last_pop_k, acc_cnt, last_iss_k, first_v_k, hold_iss, avail;
      bit nz, iv, fv, exp_rdy, exp_valid, exp_done, prev_iss, prev_acc, fin;
      logic [15:0] prev_i, prev_f;

      nz = (v.len != 0) && (v.win != 0);
      n  = v.len * v.win;
      for (int i = 0; i < n; i++) begin
         case (v.mode)
            1: begin ifd.push_back(16'(i % v.len + 1)); fd.push_back(16'(i % v.len + 5)); end
            2: begin ifd.push_back(16'd2); fd.push_back(16'd3); end
            3: begin ifd.push_back(16'(i + 1)); fd.push_back(16'd1); end
            4: begin ifd.push_back(16'hFFFD); fd.push_back(16'd4); end
            default: begin ifd.push_back(16'($urandom)); fd.push_back(16'($urandom)); end
         endcase
      end
      for (int w = 0; w < (nz ? v.win : 0); w++) begin
         s = '0;
         for (int e = 0; e < v.len; e++) s = s + prod(ifd[w*v.len+e], fd[w*v.len+e]);
`ifdef PSUM_RELU_EN
         if (s[31]) s = '0;
`endif
         expq.push_back(s);
      end

      iss = 0; pops = 0; dut_pops = 0; wdone = 0; last_pop_k = -100; acc_cnt = 0;
      last_iss_k = -100; first_v_k = -1; hold_iss = -1; prev_iss = 0; prev_acc = 0;
      prev_i = '0; prev_f = '0; first_psum = '0; fin = 0;
      @(posedge clk); #1;
      for (int k = 0; k < 3000 && !fin; k++) begin
         start       = (k == 0) || (v.spur != 0 && nz && k == 3);
         cfg_len     = (k == 0) ? LEN_W'(v.len) : LEN_W'($urandom_range(1, 9));
         cfg_num_win = (k == 0) ? WIN_W'(v.win) : WIN_W'($urandom_range(1, 9));
         if (v.tog != 0) begin
            iv = (iss < n) && (k % 2 == 0);
            fv = (iss < n);
         end else begin
            iv = (iss < n) && ($urandom_range(99) < v.pv);
            fv = (iss < n) && ($urandom_range(99) < v.pv);
         end
         ifmap_valid = iv;
         fltr_valid  = fv;
         ifmap_data  = iv ? ifd[iss] : 16'($urandom);
         fltr_data   = fv ? fd[iss] : 16'($urandom);
         psum_ready  = (k >= v.hold) && ($urandom_range(99) < v.pr);
         @(negedge clk);

         exp_rdy = nz && k >= 1 && iss < n && iv && fv && (wdone - pops < DEPTH);
         avail = 0;
         foreach (win_t[j]) if (win_t[j] + PE_LAT + 2 <= k) avail++;
         exp_valid = (avail > pops);
         exp_done  = nz ? (pops == v.win && k == last_pop_k + 2) : (k == 1);

         check("ifmap_ready", ifmap_ready, exp_rdy);
         check("fltr_ready", fltr_ready, exp_rdy);
         check("pe_ifmap", pe_ifmap, prev_iss ? prev_i : 16'h0);
         check("pe_fltr", pe_fltr, prev_iss ? prev_f : 16'h0);
         check("pe_acc_seln", pe_acc_seln, prev_acc);
         check("pe_mult_seln", pe_mult_seln, 1'b1);
         check("busy", busy, nz && k >= 1 && !exp_done);
         check("done", done, exp_done);
         check("psum_valid", psum_valid, exp_valid);

         if (pe_acc_seln) acc_cnt++;
         if (psum_valid && first_v_k < 0) first_v_k = k;
         if (k == v.hold) hold_iss = iss;
         if (psum_valid && psum_ready) dut_pops++;
         if (exp_valid && psum_ready) begin
            check("psum_data", psum_data, expq[pops]);
            if (pops == 0) first_psum = psum_data;
            pops++;
            if (pops == v.win) last_pop_k = k;
         end
         prev_iss = exp_rdy;
         prev_acc = 0;
         if (exp_rdy) begin
            prev_i   = ifd[iss];
            prev_f   = fd[iss];
            prev_acc = (iss % v.len == 0);
            if (iss % v.len == v.len - 1) begin
               win_t.push_back(k);
               wdone++;
               last_iss_k = k;
            end
            iss++;
         end
         if (exp_done) fin = 1;
         if (v.abort > 0 && iss >= v.abort) break;
         @(posedge clk); #1;
      end

      if (v.abort > 0) begin
         rstn = 1'b0;
         #1;
         check_reset("abort");
         start = 1'b0; ifmap_valid = 1'b0; fltr_valid = 1'b0; psum_ready = 1'b0;
         repeat (2) @(negedge clk);
         rstn = 1'b1;
      end else begin
         check("job_finished", fin, 1'b1);
         check("results", dut_pops, v.exp_n);
         check("acc_pulses", acc_cnt, v.exp_acc);
         check("issues", iss, n);
         if (v.exp_hold_iss >= 0) check("hold_issues", hold_iss, v.exp_hold_iss);
         if (v.chk_first != 0) check("first_psum", first_psum, v.exp_psum);
         if (v.exp_lat > 0) check("latency", first_v_k - last_iss_k, v.exp_lat);
         start = 1'b0; ifmap_valid = 1'b0; fltr_valid = 1'b0;
         repeat (2) begin
            @(negedge clk);
            check("done_once", done, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_valid", psum_valid, 1'b0);
         end
      end
   endtask

   vec_t tbl[10];
   vec_t rv;

   initial begin
      // len win mode pv tog pr hold spur | exp_n chk_first lat acc hold_iss abort | psum
      tbl[0] = '{4, 1, 1, 100, 0, 100,  0, 0, 1, 1, 5, 1, -1, 0, 32'd70};
      tbl[1] = '{3, 3, 2, 100, 0, 100,  0, 0, 3, 1, 0, 3, -1, 0, 32'd18};
      tbl[2] = '{1, 8, 3, 100, 0, 100, 40, 0, 8, 1, 0, 8,  4, 0, 32'd1};
      tbl[3] = '{4, 2, 1, 100, 1, 100,  0, 0, 2, 1, 0, 2, -1, 0, 32'd70};
      tbl[4] = '{0, 3, 0, 100, 0, 100,  0, 0, 0, 0, 0, 0, -1, 0, 32'd0};
      tbl[5] = '{5, 0, 0, 100, 0, 100,  0, 0, 0, 0, 0, 0, -1, 0, 32'd0};
      tbl[6] = '{2, 3, 0, 100, 0, 100,  0, 1, 3, 0, 0, 3, -1, 0, 32'd0};
      tbl[7] = '{3, 5, 0, 100, 0, 100,  0, 0, 0, 0, 0, 0, -1, 7, 32'd0};
      tbl[8] = '{4, 2, 1, 100, 0, 100,  0, 0, 2, 1, 0, 2, -1, 0, 32'd70};
`ifdef PSUM_RELU_EN
      tbl[9] = '{1, 1, 4, 100, 0, 100,  0, 0, 1, 1, 0, 1, -1, 0, 32'h0000_0000};
`else
      tbl[9] = '{1, 1, 4, 100, 0, 100,  0, 0, 1, 1, 0, 1, -1, 0, 32'hFFFF_FFF4};
`endif

      #1;
      check_reset("init");
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 10; i++) run_job(tbl[i]);

      for (int r = 0; r < 20; r++) begin
         rv.len = $urandom_range(1, 6);       rv.win = $urandom_range(1, 5);
         rv.mode = 0;                         rv.pv = $urandom_range(50, 100);
         rv.tog = 0;                          rv.pr = $urandom_range(30, 100);
         rv.hold = $urandom_range(0, 15);     rv.spur = $urandom_range(0, 1);
         rv.exp_n = rv.win;                   rv.chk_first = 0;
         rv.exp_lat = 0;                      rv.exp_acc = rv.win;
         rv.exp_hold_iss = -1;                rv.abort = 0;
         rv.exp_psum = '0;
         run_job(rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
